// File: rtl/mulacc_seq_if.sv
// MSP430 peripheral-bus bundle for the mulacc_seq peripheral.
interface mulacc_seq_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  modport master (output per_addr, per_din, per_en, per_we, input  per_dout);
  modport slave  (input  per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/mulacc_seq.sv
// Memory-mapped multiply-accumulate: 4-pair operand FIFO, 16-cycle shift-add engine,
// 32-bit accumulator. Define MULACC_SAT_EN to saturate the accumulator instead of wrapping.
module mulacc_seq (
  input  logic        mclk,
  input  logic        puc_rst,
  mulacc_seq_if.slave bus
);

  localparam logic [13:0] ADDR_OPA   = 14'hA8;
  localparam logic [13:0] ADDR_OPB   = 14'hA9;
  localparam logic [13:0] ADDR_ACCLO = 14'hAA;
  localparam logic [13:0] ADDR_ACCHI = 14'hAB;
  localparam logic [13:0] ADDR_CTL   = 14'hAC;
  localparam logic [13:0] ADDR_COUNT = 14'hAD;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_ACC} state_t;

  state_t      state_q;
  logic [15:0] opa_q;
  logic [15:0] fifo_a_q [4];
  logic [15:0] fifo_b_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  level_q, level_d;
  logic [31:0] mcand_q, partial_q, acc_q, acc_d;
  logic [15:0] mplier_q, count_q;
  logic [3:0]  step_q;
  logic        drop_q, ovf_q;

  logic        wr_en, rd_en, push, clr, flush, pop, push_ok, fifo_empty, fifo_full, busy;
  logic [32:0] acc_sum;
  logic [15:0] rd_data;

  assign wr_en      = bus.per_en & (bus.per_we == 2'b11);
  assign rd_en      = bus.per_en & (bus.per_we == 2'b00);
  assign push       = wr_en & (bus.per_addr == ADDR_OPB);
  assign clr        = wr_en & (bus.per_addr == ADDR_CTL) & bus.per_din[0];
  assign flush      = wr_en & (bus.per_addr == ADDR_CTL) & bus.per_din[1];
  assign fifo_empty = (level_q == 3'd0);
  assign fifo_full  = (level_q == 3'd4);
  assign busy       = (state_q != ST_IDLE) | ~fifo_empty;

  // A clear or flush on this edge must not pop a pair that would then be lost.
  assign pop     = (state_q == ST_IDLE) & ~fifo_empty & ~clr & ~flush;
  assign push_ok = push & (~fifo_full | pop);

  assign acc_sum = {1'b0, acc_q} + {1'b0, partial_q};

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    level_d = level_q;
    if (flush) level_d = 3'd0;
    else       level_d = level_q + {2'b00, push_ok} - {2'b00, pop};
`ifdef MULACC_SAT_EN
    acc_d = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
`else
    acc_d = acc_sum[31:0];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q   <= ST_IDLE;
      opa_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      step_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      drop_q    <= 1'b0;
      ovf_q     <= 1'b0;
      // NOTE: FIFO storage is cleared with the pointers so no operand survives a reset.
      for (int i = 0; i < 4; i++) begin
        fifo_a_q[i] <= '0;
        fifo_b_q[i] <= '0;
      end
    end else begin
      if (wr_en && bus.per_addr == ADDR_OPA) opa_q <= bus.per_din;

      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok) begin
          fifo_a_q[wr_ptr_q] <= opa_q;
          fifo_b_q[wr_ptr_q] <= bus.per_din;
          wr_ptr_q           <= wr_ptr_q + 2'd1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      level_q <= level_d;

      if (push && !push_ok) drop_q <= 1'b1;

      if (clr) begin
        state_q <= ST_IDLE;
        acc_q   <= '0;
        count_q <= '0;
        drop_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: if (pop) begin
            mcand_q   <= {16'h0000, fifo_a_q[rd_ptr_q]};
            mplier_q  <= fifo_b_q[rd_ptr_q];
            partial_q <= '0;
            step_q    <= '0;
            state_q   <= ST_MUL;
          end
          ST_MUL: begin
            if (mplier_q[0]) partial_q <= partial_q + mcand_q;
            mcand_q  <= {mcand_q[30:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[15:1]};
            step_q   <= step_q + 4'd1;
            if (step_q == 4'd15) state_q <= ST_ACC;
          end
          ST_ACC: begin
            acc_q   <= acc_d;
            if (acc_sum[32]) ovf_q <= 1'b1;
            count_q <= count_q + 16'd1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = 16'h0000;
    if (rd_en) begin
      case (bus.per_addr)
        ADDR_ACCLO: rd_data = acc_q[15:0];
        ADDR_ACCHI: rd_data = acc_q[31:16];
        ADDR_CTL:   rd_data = {5'b0, level_q, 3'b0, ovf_q, drop_q, fifo_full, fifo_empty, busy};
        ADDR_COUNT: rd_data = count_q;
        default:    rd_data = 16'h0000;
      endcase
    end
  end

  assign bus.per_dout = rd_data;

endmodule

// File: tb/tb_mulacc_seq.sv
// Self-checking bench for mulacc_seq: transaction-level reference model, per-cycle
// read-data compare, directed scenarios with literal expectations, then random traffic.
module tb_mulacc_seq;

  localparam logic [13:0] A_OPA = 14'hA8, A_OPB = 14'hA9, A_LO = 14'hAA,
                          A_HI = 14'hAB, A_CTL = 14'hAC, A_CNT = 14'hAD;

  logic mclk    = 1'b0;
  logic puc_rst = 1'b1;
  bit   started = 1'b0;

  mulacc_seq_if bus ();
  mulacc_seq dut (.mclk(mclk), .puc_rst(puc_rst), .bus(bus));

  always #5 mclk = ~mclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of pairs + engine countdown ----------------
  typedef struct packed { logic [15:0] a; logic [15:0] b; } pair_t;

  pair_t       m_q[$];
  logic [15:0] m_opa   = '0;
  logic [31:0] m_acc   = '0;
  logic [31:0] m_prod  = '0;
  logic [15:0] m_count = '0;
  bit          m_drop  = 1'b0;
  bit          m_ovf   = 1'b0;
  int          m_rem   = 0;   // edges until the in-flight product is accumulated

  function automatic void model_reset();
    m_q.delete();
    m_opa = '0; m_acc = '0; m_prod = '0; m_count = '0;
    m_drop = 1'b0; m_ovf = 1'b0; m_rem = 0;
  endfunction

  function automatic void model_accumulate();
    logic [32:0] s;
    s = {1'b0, m_acc} + {1'b0, m_prod};
`ifdef MULACC_SAT_EN
    if (s > 33'h0_FFFF_FFFF) begin m_acc = 32'hFFFF_FFFF; m_ovf = 1'b1; end
    else m_acc = s[31:0];
`else
    m_acc = s[31:0];
    if (s[32]) m_ovf = 1'b1;
`endif
    m_count = m_count + 16'd1;
  endfunction

  function automatic void model_step();
    bit    wr, clr, flush, push, can_pop, was_full;
    pair_t p;
    wr       = bus.per_en && (bus.per_we == 2'b11);
    clr      = wr && (bus.per_addr == A_CTL) && bus.per_din[0];
    flush    = wr && (bus.per_addr == A_CTL) && bus.per_din[1];
    push     = wr && (bus.per_addr == A_OPB);
    can_pop  = (m_rem == 0) && (m_q.size() > 0) && !clr && !flush;
    was_full = (m_q.size() == 4);
    if (clr) begin
      m_acc = '0; m_count = '0; m_drop = 1'b0; m_ovf = 1'b0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) model_accumulate();
    end
    if (can_pop) begin
      p      = m_q.pop_front();
      m_prod = 32'(p.a) * 32'(p.b);
      m_rem  = 17;  // 16 multiply edges + 1 accumulate edge after the pop
    end
    if (push) begin
      if (!was_full || can_pop) m_q.push_back(pair_t'({m_opa, bus.per_din}));
      else m_drop = 1'b1;
    end
    if (flush) m_q.delete();
    if (wr && bus.per_addr == A_OPA) m_opa = bus.per_din;
  endfunction

  function automatic logic [15:0] model_read(input logic [13:0] a);
    logic [2:0] lvl;
    bit         bsy;
    lvl = 3'(m_q.size());
    bsy = (m_rem != 0) || (m_q.size() != 0);
    case (a)
      A_LO:    return m_acc[15:0];
      A_HI:    return m_acc[31:16];
      A_CTL:   return {5'b0, lvl, 3'b0, m_ovf, m_drop, lvl == 3'd4, lvl == 3'd0, bsy};
      A_CNT:   return m_count;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) model_reset();
    else         model_step();
  end

  // Single compare process: read data is checked on every cycle, 0 when no read.
  always @(negedge mclk) begin
    #1;
    if (started)
      check("per_dout", bus.per_dout,
            (bus.per_en && bus.per_we == 2'b00) ? model_read(bus.per_addr) : 16'h0000);
  end

  // ---------------- bus tasks: each starts and ends on a falling edge ----------------
  task automatic bus_idle();
    bus.per_en   = 1'b0;
    bus.per_we   = 2'($urandom_range(0, 3));
    bus.per_addr = 14'($urandom_range(14'hA6, 14'hAF));
    bus.per_din  = 16'($urandom);
    @(negedge mclk);
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [15:0] d,
                           input logic [1:0] we = 2'b11);
    bus.per_en = 1'b1; bus.per_we = we; bus.per_addr = a; bus.per_din = d;
    @(negedge mclk);
    bus.per_en = 1'b0;
  endtask

  task automatic bus_read(input logic [13:0] a, output logic [15:0] d);
    bus.per_en = 1'b1; bus.per_we = 2'b00; bus.per_addr = a; bus.per_din = 16'($urandom);
    #1 d = bus.per_dout;
    @(negedge mclk);
    bus.per_en = 1'b0;
  endtask

  task automatic read_acc(output logic [31:0] acc);
    logic [15:0] lo, hi;
    bus_read(A_LO, lo);
    bus_read(A_HI, hi);
    acc = {hi, lo};
  endtask

  task automatic wait_idle(input int limit);
    logic [15:0] s;
    int          n = 0;
    do begin
      bus_read(A_CTL, s);
      n++;
    end while (s[0] && n < limit);
    check("idle_reached", {31'b0, s[0]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic [31:0] acc;
    logic [13:0] zero_addrs[6];
    int          op;

    bus.per_en = 1'b0; bus.per_we = 2'b00; bus.per_addr = '0; bus.per_din = '0;
    @(negedge mclk);
    started = 1'b1;
    repeat (2) @(negedge mclk);
    puc_rst = 1'b0;

    // Reset state
    bus_read(A_CTL, r);
    check("reset_stat", r, 16'h0002);
    zero_addrs = '{A_OPA, A_OPB, A_LO, A_HI, A_CNT, 14'hAE};
    foreach (zero_addrs[i]) begin
      bus_read(zero_addrs[i], r);
      check("reset_zero", r, 16'h0000);
    end

    // 3 x 5 with exact ACC latency: the k-th read follows edge E+k-1
    bus_write(A_OPA, 16'd3);
    bus_write(A_OPB, 16'd5);
    for (int k = 1; k <= 19; k++) begin
      bus_read(A_LO, r);
      if (k == 18) check("acclo_before_e18", r, 16'd0);
      if (k == 19) check("acclo_after_e18", r, 16'd15);
    end
    bus_read(A_HI, r);  check("acchi_3x5", r, 16'd0);
    bus_read(A_CNT, r); check("count_3x5", r, 16'd1);
    check("model_acc_3x5", m_acc, 32'd15);

    // Overflow + drop: first pair pops at once, four fill the FIFO, the sixth is dropped
    bus_write(A_CTL, 16'h0001);
    bus_write(A_OPA, 16'hFFFF);
    repeat (6) bus_write(A_OPB, 16'hFFFF);
    bus_read(A_CTL, r);
    check("drop_flag", {31'b0, r[3]}, 32'd1);
    check("full_flag", {31'b0, r[2]}, 32'd1);
    check("level_4", {29'b0, r[10:8]}, 32'd4);
    wait_idle(200);
    read_acc(acc);
`ifdef MULACC_SAT_EN
    check("acc_saturated", acc, 32'hFFFF_FFFF);
`else
    check("acc_wrapped", acc, 32'hFFF6_0005);
`endif
    bus_read(A_CNT, r); check("count_5", r, 16'd5);
    bus_read(A_CTL, r); check("stat_ovf_drop", r, 16'h001A);

    // CLR mid-MUL with two pairs queued
    bus_write(A_CTL, 16'h0001);
    bus_write(A_OPA, 16'd100); bus_write(A_OPB, 16'd100);
    bus_write(A_OPA, 16'd2);   bus_write(A_OPB, 16'd3);
    bus_write(A_OPA, 16'd4);   bus_write(A_OPB, 16'd5);
    repeat (3) bus_idle();
    bus_write(A_CTL, 16'h0001);
    read_acc(acc);      check("clr_acc", acc, 32'd0);
    bus_read(A_CNT, r); check("clr_count", r, 16'd0);
    wait_idle(200);
    read_acc(acc);      check("after_clr_acc", acc, 32'd26);
    bus_read(A_CNT, r); check("after_clr_count", r, 16'd2);

    // CLR|FLUSH with three pairs queued
    bus_write(A_CTL, 16'h0001);
    bus_write(A_OPA, 16'd7);
    for (int i = 1; i <= 4; i++) bus_write(A_OPB, 16'(i));
    repeat (2) bus_idle();
    bus_write(A_CTL, 16'h0003);
    bus_read(A_CTL, r); check("flush_stat", r, 16'h0002);
    repeat (30) bus_idle();
    read_acc(acc);      check("flush_acc", acc, 32'd0);

    // Asynchronous reset mid-MUL
    bus_write(A_OPA, 16'h1234);
    bus_write(A_OPB, 16'h5678);
    repeat (5) bus_idle();
    #3 puc_rst = 1'b1;
    @(negedge mclk);
    bus_read(A_CTL, r); check("async_rst_stat", r, 16'h0002);
    read_acc(acc);      check("async_rst_acc", acc, 32'd0);
    bus_read(A_CNT, r); check("async_rst_count", r, 16'd0);
    puc_rst = 1'b0;
    bus_write(A_OPA, 16'd7);
    bus_write(A_OPB, 16'd9);
    wait_idle(200);
    read_acc(acc);      check("post_rst_7x9", acc, 32'd63);

    // Random traffic, checked every cycle by the compare process
    bus_write(A_CTL, 16'h0001);
    for (int i = 0; i < 2500; i++) begin
      op = $urandom_range(0, 99);
      if (op < 25)      bus_write(A_OPA, ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 15)));
      else if (op < 55) bus_write(A_OPB, 16'($urandom));
      else if (op < 58) bus_write(A_CTL, 16'($urandom_range(0, 3)));
      else if (op < 66) bus_write(14'($urandom_range(14'hA8, 14'hAD)), 16'($urandom),
                                  2'($urandom_range(1, 2)));
      else if (op < 88) bus_read(14'($urandom_range(14'hA6, 14'hAF)), r);
      else              bus_idle();
    end
    wait_idle(200);
    read_acc(acc);
    check("random_final_acc", acc, m_acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
